ni_inject_fifo: RTL and testbench
=================================

# ni_inject_fifo

Network-interface injection stage that sits directly downstream of the per-node data-out buffers. It consumes the raw 20-bit word stream and its valid, frames each contiguous burst into a packet by tagging every flit HEAD/BODY/TAIL/SINGLE, and buffers the flits in a FIFO. It presents the flits to the router local input port with a valid/ready handshake. It also generates the buffer's `enable` so that a packet is only requested when the FIFO can absorb it whole.

## Interface
- `DEPTH`, 32: FIFO entries. Power of two, ≥ `PKT_MAX`+1.
- `FLIT_W`, 20: payload width.
- `PKT_MAX`, 30: maximum flits per packet. Used for the space check.
- `clk`  in  1: single clock, rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse requesting injection of one packet.
- `inj_enable`  out  1: drives the upstream buffer `enable`.
- `in_data`  in  FLIT_W: upstream word (buffer `dataout`).
- `in_valid`  in  1: upstream word valid (buffer `out_valid`). There is no backpressure toward upstream.
- `out_flit`  out  FLIT_W+2: `{type[1:0], payload}`. Types: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, SINGLE=2'b11.
- `out_valid`  out  1: FIFO not empty.
- `out_ready`  in  1: router accepts `out_flit`.
- `pkt_count`  out  8: packets fully popped (TAIL or SINGLE). Wraps at 255→0.
- `overflow`  out  1: sticky; set when a flit is dropped because the FIFO is full.

## Operation
- **Framing register** (`hold`, `hold_v`, `first`):
  - `in_valid`=1 and `hold_v`=0: capture the word, set `hold_v`=1. `first` remains 1.
  - `in_valid`=1 and `hold_v`=1: push `hold` with type HEAD if `first`, otherwise BODY. Capture the new word and clear `first`.
  - `in_valid`=0 and `hold_v`=1: push `hold` with type TAIL, or SINGLE if `first`. Clear `hold_v` and set `first`=1.
  - Result: a single-cycle gap in `in_valid` ends a packet.
- **FIFO:**
  - First-word-fall-through. `out_flit` is the head entry and `out_valid` = !empty.
  - Pop when `out_valid && out_ready`.
  - Push is accepted if not full, or if a pop occurs in the same cycle. Otherwise the flit is dropped, `overflow` is set to 1, and `count` is unchanged.
  - `count` is $clog2(DEPTH)+1 bits; `free` = DEPTH − count.
  - Pointers wrap modulo DEPTH.
- **Enable FSM** (`inj_enable` = 1 only in ARMED):
  - IDLE: on `start`, go to ARMED if `free` ≥ PKT_MAX+1, otherwise go to WAIT.
  - WAIT: go to ARMED once `free` ≥ PKT_MAX+1.
  - ARMED: go to IDLE in the cycle a TAIL or SINGLE push occurs.
  - `start` pulses outside IDLE are ignored.
- **`pkt_count`:** increments on a pop whose type is TAIL or SINGLE.

## Timing
- **Reset values:** `inj_enable`=0, `out_valid`=0, `out_flit`=0, `pkt_count`=0, `overflow`=0. Also `hold_v`=0, `first`=1, pointers and count = 0, FSM = IDLE.
  - Reset is sampled on `clk` only and overrides all activity, including a mid-packet abort.
  - After a mid-packet reset, partial flits are discarded.
- **Data latency:**
  - A word valid in cycle t enters `hold` at the end of t and is pushed at the end of t+1.
  - With an empty FIFO, `out_valid`=1 in cycle t+2.
- **Throughput:** one push and one pop per cycle, sustained.
- **FSM response:** `start` in cycle t with enough space gives `inj_enable`=1 in cycle t+1.
- **Full/empty boundaries:**
  - Empty with a simultaneous push: no pop that cycle (FWFT data appears the next cycle).
  - Full with a simultaneous push and pop: both are performed, and `count` stays at DEPTH.
- **Count arithmetic:** unsigned, never wraps below 0 or above DEPTH.

## Structure
- Shared package `noc_pkg`: flit type localparams (HEAD/BODY/TAIL/SINGLE), `FLIT_W`, `PKT_MAX`, and the FSM state encoding (IDLE=0, WAIT=1, ARMED=2).
- One sub-module: `ni_sync_fifo` (parameterised width/depth, FWFT, count output). Framing, FSM and counters stay in the top module.

## Test plan
- **30-word burst:** `start`, 30 consecutive valid words 0..29, `out_ready`=1 → 30 flits: HEAD(0), BODY(1..28), TAIL(29). `pkt_count`=1, `inj_enable` back to 0 the cycle after the TAIL push.
- **Single word:** one valid word 0x5A5A5 → one flit {SINGLE, 0x5A5A5}, `pkt_count`=1.
- **Backpressure:** `out_ready`=0 during a 30-word burst → `count`=30 and no `overflow`. Releasing `out_ready` drains all 30 flits in order over 30 cycles.
- **Insufficient space:** 30 flits held with DEPTH=32, then `start` → FSM in WAIT and `inj_enable` stays 0. Popping one flit gives `free`=3 (still WAIT); pop until `free` ≥ 31, then ARMED the next cycle.
- **Overflow:** force 33 valid words with `out_ready`=0 (ignoring `inj_enable`) → 32 stored, `overflow`=1 and stays set.
- **Full push/pop:** FIFO full, simultaneous push and pop → `count` remains 32, order preserved.
- **Mid-packet reset:** `RST` asserted for 1 cycle at word 10 of a burst → all outputs at reset values the next cycle. A subsequent burst starts with a HEAD flit.

Source files
------------

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : noc_pkg
//  Purpose  : Shared definitions for the NoC network-interface injection path:
//             flit type codes, default payload width / packet length and the
//             injection-enable state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package noc_pkg;

    localparam int c_FLIT_W  = 20;
    localparam int c_PKT_MAX = 30;

    // Flit type codes carried in the two MSBs of every flit.
    // Bit 0 set marks the last flit of a packet (TAIL or SINGLE).
    localparam logic [1:0] c_HEAD   = 2'b10;
    localparam logic [1:0] c_BODY   = 2'b00;
    localparam logic [1:0] c_TAIL   = 2'b01;
    localparam logic [1:0] c_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ARMED = 2'd2
    } inj_state_t;

    function automatic logic is_last(input logic [1:0] ftype);
        return ftype[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ni_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ni_sync_fifo
//  Purpose  : Single-clock first-word-fall-through FIFO with occupancy count.
//             A push into a full FIFO is still accepted when a pop happens in
//             the same cycle.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             i_push, i_data  - write request and data
//             i_pop           - read request (ignored while empty)
//             o_data          - head entry (zero while empty)
//             o_empty         - no entries held
//             o_count         - number of entries held (0..DEPTH)
//             o_push_ok       - the current push request is accepted
//  Revision : 1.0  initial release
// ============================================================================
module ni_sync_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_push_ok
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty   = w_empty;
    assign o_count   = r_count;
    assign o_push_ok = w_push;

endmodule
`default_nettype wire

// File: rtl/ni_inject_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ni_inject_fifo
//  Purpose  : NI injection stage. Frames the raw upstream word stream into
//             packets (HEAD/BODY/TAIL/SINGLE), buffers flits in a FWFT FIFO
//             toward the router local port and generates the upstream buffer
//             enable only when a whole packet fits.
//  Ports    : clk, RST             - clock, synchronous active-high reset
//             start                - request injection of one packet
//             inj_enable           - upstream buffer enable
//             in_data, in_valid    - upstream word stream (no backpressure)
//             out_flit, out_valid  - {type, payload} toward router
//             out_ready            - router accepts out_flit
//             pkt_count            - packets fully popped (wraps)
//             overflow             - sticky flit-drop flag
//  Revision : 1.0  initial release
// ============================================================================
module ni_inject_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int FLIT_W  = c_FLIT_W,
    parameter int PKT_MAX = c_PKT_MAX
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    output logic              inj_enable,
    input  logic [FLIT_W-1:0] in_data,
    input  logic              in_valid,
    output logic [FLIT_W+1:0] out_flit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        pkt_count,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);

    // Framing register
    logic [FLIT_W-1:0] r_hold;
    logic              r_hold_v;
    logic              r_first;

    logic              w_push;
    logic              w_last_push;
    logic [1:0]        w_type;
    logic              w_pop;
    logic              w_empty;
    logic              w_push_ok;
    logic [AW:0]       w_count;
    logic [AW:0]       w_free;
    logic              w_space_ok;

    inj_state_t        r_state;
    logic              r_inj_enable;
    logic [7:0]        r_pkt_count;
    logic              r_overflow;

    // The held word is emitted whenever it is valid; whether the next word
    // follows immediately decides if the packet continues or closes.
    assign w_push      = r_hold_v;
    assign w_last_push = r_hold_v && !in_valid;
    assign w_type      = in_valid ? (r_first ? c_HEAD   : c_BODY)
                                  : (r_first ? c_SINGLE : c_TAIL);

    always_ff @(posedge clk) begin
        if (RST) begin
            r_hold   <= '0;
            r_hold_v <= 1'b0;
            r_first  <= 1'b1;
        end else if (in_valid) begin
            r_hold   <= in_data;
            r_hold_v <= 1'b1;
            if (r_hold_v) r_first <= 1'b0;
        end else if (r_hold_v) begin
            r_hold_v <= 1'b0;
            r_first  <= 1'b1;
        end
    end

    assign w_pop = !w_empty && out_ready;

    ni_sync_fifo #(
        .WIDTH (FLIT_W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (RST),
        .i_push    (w_push),
        .i_data    ({w_type, r_hold}),
        .i_pop     (w_pop),
        .o_data    (out_flit),
        .o_empty   (w_empty),
        .o_count   (w_count),
        .o_push_ok (w_push_ok)
    );

    assign w_free     = (AW+1)'(DEPTH) - w_count;
    assign w_space_ok = (w_free >= (AW+1)'(PKT_MAX + 1));

    // Enable FSM; inj_enable is registered alongside the state so it is high
    // exactly while ARMED.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_inj_enable <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_space_ok) begin
                            r_state      <= ST_ARMED;
                            r_inj_enable <= 1'b1;
                        end else begin
                            r_state      <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_space_ok) begin
                        r_state      <= ST_ARMED;
                        r_inj_enable <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (w_last_push) begin
                        r_state      <= ST_IDLE;
                        r_inj_enable <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_inj_enable <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_pkt_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_pop && is_last(out_flit[FLIT_W+1:FLIT_W])) begin
                r_pkt_count <= r_pkt_count + 1'b1;
            end
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign inj_enable = r_inj_enable;
    assign out_valid  = !w_empty;
    assign pkt_count  = r_pkt_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ni_inject_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ni_inject_fifo
//  Purpose  : Self-checking bench for ni_inject_fifo: table of packet bursts
//             plus directed sequences for backpressure, space wait, overflow,
//             full push/pop and mid-packet reset. Popped flits are checked
//             against a queue of expected flits filled as words are driven.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ni_inject_fifo;
    import noc_pkg::*;

    logic        clk;
    logic        RST;
    logic        start;
    logic        inj_enable;
    logic [19:0] in_data;
    logic        in_valid;
    logic [21:0] out_flit;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  pkt_count;
    logic        overflow;

    ni_inject_fifo #(.DEPTH(32), .FLIT_W(20), .PKT_MAX(30)) dut (
        .clk        (clk),
        .RST        (RST),
        .start      (start),
        .inj_enable (inj_enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pkt_count  (pkt_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [19:0] base;
        bit          rnd_ready;
        int          exp_pkts;
    } vec_t;

    vec_t        vecs [5];
    logic [21:0] sb [$];
    int          n_checks;
    int          n_fail;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: compare any pop at the negedge, return 1 after the posedge.
    task automatic tick();
        logic [21:0] e;
        @(negedge clk);
        if (!RST && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", {10'd0, out_flit}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("flit_order", {10'd0, out_flit}, {10'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ftype(input int i, input int len);
        if (len == 1)       return c_SINGLE;
        if (i == 0)         return c_HEAD;
        if (i == len - 1)   return c_TAIL;
        return c_BODY;
    endfunction

    // Drives a contiguous burst; returns in the gap cycle (in_valid=0).
    task automatic send_pkt(input int len, input logic [19:0] base, input bit rnd, input bit rdy);
        for (int i = 0; i < len; i++) begin
            in_valid  = 1'b1;
            in_data   = base + 20'(i);
            sb.push_back({ftype(i, len), in_data});
            out_ready = rnd ? 1'($urandom_range(0, 1)) : rdy;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        check("drain_done", {31'd0, (sb.size() == 0 && !out_valid)}, 32'd1);
        out_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{len: 30, base: 20'h00000, rnd_ready: 1'b0, exp_pkts: 1};
        vecs[1] = '{len: 1,  base: 20'h5A5A5, rnd_ready: 1'b0, exp_pkts: 2};
        vecs[2] = '{len: 2,  base: 20'h00100, rnd_ready: 1'b0, exp_pkts: 3};
        vecs[3] = '{len: 3,  base: 20'hFFFFE, rnd_ready: 1'b0, exp_pkts: 4};
        vecs[4] = '{len: 5,  base: 20'h12345, rnd_ready: 1'b1, exp_pkts: 5};

        RST = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        RST = 1'b0;
        check("rst_inj_enable", {31'd0, inj_enable}, 32'd0);
        check("rst_out_valid",  {31'd0, out_valid},  32'd0);
        check("rst_out_flit",   {10'd0, out_flit},   32'd0);
        check("rst_pkt_count",  {24'd0, pkt_count},  32'd0);
        check("rst_overflow",   {31'd0, overflow},   32'd0);

        // Table of bursts
        for (int v = 0; v < 5; v++) begin
            out_ready = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            check("start_to_enable", {31'd0, inj_enable}, 32'd1);
            send_pkt(vecs[v].len, vecs[v].base, vecs[v].rnd_ready, 1'b1);
            check("enable_in_tail_cycle", {31'd0, inj_enable}, 32'd1);
            tick();
            check("enable_after_tail", {31'd0, inj_enable}, 32'd0);
            drain(vecs[v].rnd_ready);
            check("pkt_count_table", {24'd0, pkt_count}, 32'(vecs[v].exp_pkts));
        end

        // Backpressure: 30 flits held, then drained in 30 cycles
        out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        send_pkt(30, 20'h01000, 1'b0, 1'b0);
        tick();
        check("bp_count",    32'(dut.w_count), 32'd30);
        check("bp_overflow", {31'd0, overflow}, 32'd0);
        check("bp_head",     {10'd0, out_flit}, {10'd0, c_HEAD, 20'h01000});
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 40) begin
            tick();
            n++;
        end
        check("bp_drain_cycles", 32'(n), 32'd30);
        check("bp_pkt_count", {24'd0, pkt_count}, 32'd6);

        // Insufficient space: 30 held, start waits
        out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        send_pkt(30, 20'h02000, 1'b0, 1'b0);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        check("wait_state",  32'(dut.r_state), 32'(ST_WAIT));
        check("wait_enable", {31'd0, inj_enable}, 32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("wait_count_29", 32'(dut.w_count), 32'd29);
        check("wait_free3_enable", {31'd0, inj_enable}, 32'd0);
        out_ready = 1'b1;
        repeat (28) tick();
        out_ready = 1'b0;
        check("wait_count_1", 32'(dut.w_count), 32'd1);
        check("wait_free31_enable", {31'd0, inj_enable}, 32'd0);
        tick();
        check("armed_after_space", {31'd0, inj_enable}, 32'd1);
        send_pkt(1, 20'h07777, 1'b0, 1'b1);
        tick();
        drain(1'b0);
        check("wait_pkt_count", {24'd0, pkt_count}, 32'd8);

        // Overflow: 33 words forced with no pops
        out_ready = 1'b0;
        for (int i = 0; i < 33; i++) begin
            in_valid = 1'b1;
            in_data  = 20'h00200 + 20'(i);
            if (i < 32) sb.push_back({(i == 0) ? c_HEAD : c_BODY, in_data});
            tick();
        end
        in_valid = 1'b0;
        check("ovf_full_count",   32'(dut.w_count), 32'd32);
        check("ovf_not_yet",      {31'd0, overflow}, 32'd0);
        tick();
        check("ovf_set",          {31'd0, overflow}, 32'd1);
        check("ovf_count_stays",  32'(dut.w_count), 32'd32);
        tick();
        check("ovf_sticky",       {31'd0, overflow}, 32'd1);

        // Full with simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_data   = 20'h00300 + 20'(i);
            sb.push_back({ftype(i, 3), in_data});
            out_ready = (i != 0);
            tick();
            if (i != 0) check("full_pushpop_count", 32'(dut.w_count), 32'd32);
        end
        in_valid = 1'b0;
        tick();
        check("full_tail_count", 32'(dut.w_count), 32'd32);
        drain(1'b0);
        check("full_pkt_count", {24'd0, pkt_count}, 32'd9);

        // Mid-packet reset at word 10
        out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = 20'h00400 + 20'(i);
            if (i == 10) RST = 1'b1;
            tick();
        end
        RST = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("mrst_inj_enable", {31'd0, inj_enable}, 32'd0);
        check("mrst_out_valid",  {31'd0, out_valid},  32'd0);
        check("mrst_out_flit",   {10'd0, out_flit},   32'd0);
        check("mrst_pkt_count",  {24'd0, pkt_count},  32'd0);
        check("mrst_overflow",   {31'd0, overflow},   32'd0);
        check("mrst_count",      32'(dut.w_count),    32'd0);
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check("mrst_rearm", {31'd0, inj_enable}, 32'd1);
        send_pkt(4, 20'h00500, 1'b0, 1'b1);
        tick();
        drain(1'b0);
        check("mrst_pkt_count_after", {24'd0, pkt_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
